// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter feeding NUM_WR writers and NUM_RD readers into one SRAM
// command port; a tag FIFO steers in-order read data back to its requester.
module sram_rr_arbiter #(
  parameter int NUM_WR    = 2,
  parameter int NUM_RD    = 2,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                                        sram_clock,
  input  logic                                        reset,
  input  logic [NUM_WR-1:0]                           wr_valid,
  output logic [NUM_WR-1:0]                           wr_pop,
  input  logic [NUM_WR*(MASK_W+ADDR_W+DATA_W)-1:0]    wr_req,
  input  logic [NUM_RD-1:0]                           rd_valid,
  output logic [NUM_RD-1:0]                           rd_pop,
  input  logic [NUM_RD*ADDR_W-1:0]                    rd_addr,
  input  logic [NUM_RD-1:0]                           rd_resp_full,
  output logic [NUM_RD-1:0]                           rd_resp_wr,
  output logic [DATA_W-1:0]                           rd_resp_data,
  output logic                                        sram_addr_valid,
  input  logic                                        sram_ready,
  output logic [ADDR_W-1:0]                           sram_addr,
  output logic [DATA_W-1:0]                           sram_data_in,
  output logic [MASK_W-1:0]                           sram_write_mask,
  input  logic [DATA_W-1:0]                           sram_data_out,
  input  logic                                        sram_data_out_valid,
  output logic [$clog2(TAG_DEPTH):0]                  outstanding,
  output logic                                        resp_underflow
);

  localparam int N  = NUM_WR + NUM_RD;
  localparam int IW = $clog2(N);
  localparam int RW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int WW = MASK_W + ADDR_W + DATA_W;

  logic [IW-1:0]     last_q, last_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic [MASK_W-1:0] cmd_mask_q, cmd_mask_d;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [NUM_RD-1:0] resp_wr_q, resp_wr_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              uflow_q, uflow_d;
  logic [RW-1:0]     tag_mem_q [TAG_DEPTH];

  logic [(1<<IW)-1:0] elig;
  logic [IW:0]        cand;
  logic [IW-1:0]      gidx;
  logic               gnt_any, gnt, free, tag_full;
  logic               wr_hit, rd_hit, tpush, tpop;
  logic [WW-1:0]      wsel;
  logic [ADDR_W-1:0]  rsel;
  logic [RW-1:0]      rport, head;

  assign free     = ~cmd_valid_q | sram_ready;
  assign tag_full = (cnt_q == (PW+1)'(TAG_DEPTH));
  assign head     = tag_mem_q[rp_q];

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_WR; i++) elig[i] = wr_valid[i];
    for (int j = 0; j < NUM_RD; j++)
      elig[NUM_WR+j] = rd_valid[j] & ~rd_resp_full[j] & ~tag_full;
  end

  // Search starts one past the last winner and wraps modulo N.
  always_comb begin
    gnt_any = 1'b0;
    gidx    = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!gnt_any && elig[cand[IW-1:0]]) begin
        gnt_any = 1'b1;
        gidx    = cand[IW-1:0];
      end
    end
  end

  assign gnt = gnt_any & free;

  always_comb begin
    wr_pop = '0;
    rd_pop = '0;
    wr_hit = 1'b0;
    rd_hit = 1'b0;
    wsel   = '0;
    rsel   = '0;
    rport  = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (gidx == IW'(i)) begin
        wr_hit    = 1'b1;
        wsel      = wr_req[i*WW +: WW];
        wr_pop[i] = gnt;
      end
    end
    for (int j = 0; j < NUM_RD; j++) begin
      if (gidx == IW'(NUM_WR + j)) begin
        rd_hit    = 1'b1;
        rsel      = rd_addr[j*ADDR_W +: ADDR_W];
        rport     = RW'(j);
        rd_pop[j] = gnt;
      end
    end
  end

  assign tpush = gnt & rd_hit;
  assign tpop  = sram_data_out_valid & (cnt_q != '0);

  always_comb begin
    last_d      = gnt ? gidx : last_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_mask_d  = cmd_mask_q;
    if (free) begin
      cmd_valid_d = 1'b0;
      if (tpush) begin
        cmd_valid_d = 1'b1;
        cmd_addr_d  = rsel;
        cmd_data_d  = '0;
        cmd_mask_d  = '0;
      end else if (gnt && wr_hit && wsel[WW-1 -: MASK_W] != '0) begin
        cmd_valid_d = 1'b1;
        cmd_mask_d  = wsel[WW-1 -: MASK_W];
        cmd_addr_d  = wsel[DATA_W +: ADDR_W];
        cmd_data_d  = wsel[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    wp_d        = wp_q + PW'(tpush);
    rp_d        = rp_q + PW'(tpop);
    cnt_d       = cnt_q + (PW+1)'(tpush) - (PW+1)'(tpop);
    uflow_d     = uflow_q | (sram_data_out_valid & (cnt_q == '0));
    resp_data_d = tpop ? sram_data_out : resp_data_q;
    resp_wr_d   = '0;
    for (int j = 0; j < NUM_RD; j++)
      resp_wr_d[j] = tpop & (head == RW'(j));
  end

  always_ff @(posedge sram_clock) begin
    if (reset) begin
      last_q      <= IW'(N - 1);
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_mask_q  <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      resp_wr_q   <= '0;
      resp_data_q <= '0;
      uflow_q     <= 1'b0;
    end else begin
      last_q      <= last_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_mask_q  <= cmd_mask_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      resp_wr_q   <= resp_wr_d;
      resp_data_q <= resp_data_d;
      uflow_q     <= uflow_d;
    end
  end

  always_ff @(posedge sram_clock) begin
    if (tpush) tag_mem_q[wp_q] <= rport;
  end

  assign sram_addr_valid = cmd_valid_q;
  assign sram_addr       = cmd_addr_q;
  assign sram_data_in    = cmd_data_q;
  assign sram_write_mask = cmd_mask_q;
  assign rd_resp_wr      = resp_wr_q;
  assign rd_resp_data    = resp_data_q;
  assign outstanding     = cnt_q;
  assign resp_underflow  = uflow_q;

endmodule
